// File: rtl/shr_seq_32.sv
// Multi-cycle 32-bit right shifter: latches operand/amount/mode on start,
// shifts one bit per clock, then pulses done and holds the result.
module shr_seq_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        arith,
    input  logic [31:0] in,
    input  logic [4:0]  shamt,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        am_q, am_d;
    logic [31:0] out_q, out_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        am_d    = am_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    out_d   = in;
                    am_d    = arith;
                    cnt_d   = shamt;
                    state_d = (shamt == 5'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // Sign fill comes from the current MSB, which is preserved each step.
                out_d = {(am_q ? out_q[31] : 1'b0), out_q[31:1]};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            am_q    <= 1'b0;
            out_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            am_q    <= am_d;
            out_q   <= out_d;
        end
    end

    assign out  = out_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_shr_seq_32.sv
// Directed and random checks for shr_seq_32 with a result scoreboard.
module tb_shr_seq_32;

    logic        clk;
    logic        reset;
    logic        start;
    logic        arith;
    logic [31:0] in;
    logic [4:0]  shamt;
    logic [31:0] out;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] exp_out;
        int          exp_sh;
    } sb_entry_t;

    sb_entry_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    shr_seq_32 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .arith (arith),
        .in    (in),
        .shamt (shamt),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, then follow it to its done pulse.
    task automatic run_op(input string tag, input logic [31:0] in_v, input logic [4:0] sh_v,
                          input logic ar_v, input logic [31:0] exp_v, input bit disturb);
        sb_entry_t e;
        int edges;
        int busy_cnt;
        bit got;
        in    = in_v;
        shamt = sh_v;
        arith = ar_v;
        start = 1'b1;
        sb.push_back('{exp_out: exp_v, exp_sh: int'(sh_v)});
        tick();
        start    = 1'b0;
        in       = ~in_v;
        shamt    = ~sh_v;
        arith    = ~ar_v;
        edges    = 1;
        busy_cnt = 0;
        got      = 1'b0;
        while (!got && edges <= 40) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                if (disturb && busy_cnt == 2) begin
                    start = 1'b1;
                    in    = 32'h0;
                    shamt = 5'd1;
                end else begin
                    start = 1'b0;
                end
                tick();
                edges++;
            end
        end
        start = 1'b0;
        if (!got) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk({tag, "_out"}, out, e.exp_out);
            chk({tag, "_latency"}, edges, e.exp_sh + 1);
            chk({tag, "_busy_cycles"}, busy_cnt, e.exp_sh);
            chk({tag, "_busy_at_done"}, busy, 1'b0);
            tick();
            chk({tag, "_done_width"}, done, 1'b0);
            chk({tag, "_hold"}, out, e.exp_out);
        end
        $display("op %s in=%h shamt=%0d arith=%0d -> out=%h", tag, in_v, sh_v, ar_v, out);
    endtask

    initial begin
        logic [31:0] rin;
        logic [4:0]  rsh;
        logic        rar;
        logic [31:0] rexp;
        int          seen_done;

        reset = 1'b1;
        start = 1'b1;
        arith = 1'b1;
        in    = 32'hDEADBEEF;
        shamt = 5'd3;
        tick();
        tick();
        chk("reset_out", out, 32'd0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        $display("reset applied: out=%h busy=%0d done=%0d", out, busy, done);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_busy", busy, 1'b0);
        chk("idle_out", out, 32'd0);

        run_op("lsr4",   32'h80000000, 5'd4,  1'b0, 32'h08000000, 1'b0);
        run_op("asr4",   32'h80000000, 5'd4,  1'b1, 32'hF8000000, 1'b0);
        run_op("asr31",  32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 1'b0);
        run_op("lsr31",  32'h80000000, 5'd31, 1'b0, 32'h00000001, 1'b0);
        run_op("sh0",    32'h1234ABCD, 5'd0,  1'b0, 32'h1234ABCD, 1'b0);
        run_op("ignore", 32'hFFFF0000, 5'd16, 1'b0, 32'h0000FFFF, 1'b1);

        for (int i = 0; i < 6; i++) begin
            rin  = $urandom;
            rsh  = 5'($urandom_range(0, 31));
            rar  = 1'($urandom_range(0, 1));
            rexp = rar ? 32'($signed(rin) >>> rsh) : (rin >> rsh);
            run_op($sformatf("rnd%0d", i), rin, rsh, rar, rexp, 1'b0);
        end

        // Abort in the third SHIFT cycle of a 10-bit shift.
        in    = 32'hA5A5A5A5;
        shamt = 5'd10;
        arith = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_out", out, 32'd0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        seen_done = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);
        $display("abort: out=%h busy=%0d done_pulses=%0d", out, busy, seen_done);

        run_op("post_abort", 32'hA5A5A5A5, 5'd10, 1'b1, 32'hFFE96969, 1'b0);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
